i2c_target: RTL and testbench

I2C target (slave) endpoint that answers the bus transactions issued by the team's I2C controller. It samples open-drain SCL/SDA in the system clock domain and detects START, repeated START and STOP. It decodes a 7-bit target address followed by an 8-bit memory address, then drives a byte-wide register port for writes and reads with auto-increment. It sits between the board-level I2C pins (SDA pad via open-drain enable) and a local register file.

---
 rtl/i2c_pkg.sv | 38 +++
 rtl/i2c_sync_edge.sv | 54 +++++
 rtl/i2c_target.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_i2c_target.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// -----------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the I2C target endpoint:
//   - i2c_tgt_state_t : protocol FSM state encoding (also exported on the
//                       top-level debug port)
//   - BYTE_BITS       : bits per I2C byte
//   - ACK_LVL         : SDA level that means ACK
//   - RW_WRITE/RW_READ: encoding of the R/W bit (LSB of the address byte)
//   - addr_match()    : compares the 7-bit address field of an address byte
// -----------------------------------------------------------------------------
package i2c_pkg;

    localparam int   BYTE_BITS = 8;
    localparam logic ACK_LVL   = 1'b0;

    localparam logic RW_WRITE  = 1'b0;
    localparam logic RW_READ   = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_MADDR     = 4'd3,
        ST_MADDR_ACK = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
        ST_RDATA     = 4'd7,
        ST_RDATA_ACK = 4'd8,
        ST_WAIT_STOP = 4'd9
    } i2c_tgt_state_t;

    // True when bits [7:1] of a received address byte equal the target address.
    function automatic logic addr_match(input logic [7:0] addr_byte,
                                        input logic [6:0] target_addr);
        return addr_byte[7:1] == target_addr;
    endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// -----------------------------------------------------------------------------
// i2c_sync_edge
// Multi-flop synchronizer for one raw bus pin followed by a registered edge
// detector. level_o, rise_o and fall_o are mutually aligned: rise_o/fall_o are
// high for exactly one clk in the same cycle that level_o shows the new value.
// Pin-to-output latency is STAGES + 1 clk.
//
// Ports:
//   clk_i    in   system clock
//   reset_i  in   synchronous active-high reset
//   din_i    in   raw asynchronous pin level
//   level_o  out  synchronized level
//   rise_o   out  one-clk pulse on a 0->1 transition
//   fall_o   out  one-clk pulse on a 1->0 transition
//
// STAGES must be at least 2. RST_VAL is the idle bus level (pull-up = 1), so
// reset never manufactures an edge on an idle line.
// -----------------------------------------------------------------------------
module i2c_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic din_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              level_q;
    logic              rise_q;
    logic              fall_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_q  <= {STAGES{RST_VAL}};
            level_q <= RST_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[STAGES-2:0], din_i};
            level_q <= sync_q[STAGES-1];
            rise_q  <= sync_q[STAGES-1] & ~level_q;
            fall_q  <= ~sync_q[STAGES-1] & level_q;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_target.sv
// -----------------------------------------------------------------------------
// i2c_target
// I2C target endpoint. Answers the address SLAVE_ADDR, takes an 8-bit memory
// address, then writes or reads a byte-wide register port with auto-increment
// (address wraps 8'hFF -> 8'h00).
//
// Ports:
//   clk        in   system clock, at least 8x the SCL frequency
//   reset      in   synchronous active-high reset
//   scl_in     in   raw SCL pin level
//   sda_in     in   raw SDA pin level
//   sda_oe     out  1 = pull SDA low, 0 = release
//   reg_addr   out  current memory address
//   reg_wdata  out  write data, valid with reg_we
//   reg_we     out  one-clk write strobe
//   reg_re     out  one-clk read request; reg_rdata is captured on the next clk
//   reg_rdata  in   read data
//   busy       out  high from a matching address ACK until STOP/START/mismatch
//   state_o    out  current FSM state (debug visibility)
//
// Register port handshake: reg_we and reg_re are single-cycle strobes with no
// back-pressure. reg_addr/reg_wdata are valid in the strobe cycle; for a read
// the register file must present reg_rdata for reg_addr in the cycle after
// reg_re, when it is loaded into the shift register.
//
// Bus timing: bits are sampled on detected SCL rises; sda_oe only moves in
// response to detected SCL falls (or while SCL is low), never while SCL is
// high, so the target never creates a false START/STOP.
// -----------------------------------------------------------------------------
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = 7'h55,
    parameter int         SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           scl_in,
    input  logic           sda_in,
    output logic           sda_oe,
    output logic [7:0]     reg_addr,
    output logic [7:0]     reg_wdata,
    output logic           reg_we,
    output logic           reg_re,
    input  logic [7:0]     reg_rdata,
    output logic           busy,
    output i2c_tgt_state_t state_o
);

    // -------------------------------------------------------------------------
    // Pin synchronization and bus condition detection
    // -------------------------------------------------------------------------
    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_scl_sync (
        .clk_i   (clk),
        .reset_i (reset),
        .din_i   (scl_in),
        .level_o (scl_lvl),
        .rise_o  (scl_rise),
        .fall_o  (scl_fall)
    );

    i2c_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sda_sync (
        .clk_i   (clk),
        .reset_i (reset),
        .din_i   (sda_in),
        .level_o (sda_lvl),
        .rise_o  (sda_rise),
        .fall_o  (sda_fall)
    );

    // SDA edges while SCL is high are bus conditions, not data.
    logic start_det, stop_det;
    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    i2c_tgt_state_t state_q, state_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic           byte_full_q, byte_full_d;   // 8 bits shifted, awaiting SCL fall
    logic [7:0]     shift_q, shift_d;
    logic           sda_oe_q, sda_oe_d;
    logic [7:0]     reg_addr_q, reg_addr_d;
    logic [7:0]     reg_wdata_q, reg_wdata_d;
    logic           reg_we_q, reg_we_d;
    logic           reg_re_q, reg_re_d;
    logic           busy_q, busy_d;

    // States in which each SCL rise carries a data bit that is counted.
    logic count_bits;
    assign count_bits = (state_q == ST_ADDR)  || (state_q == ST_MADDR) ||
                        (state_q == ST_WDATA) || (state_q == ST_RDATA);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            byte_full_q <= 1'b0;
            shift_q     <= 8'h00;
            sda_oe_q    <= 1'b0;
            reg_addr_q  <= 8'h00;
            reg_wdata_q <= 8'h00;
            reg_we_q    <= 1'b0;
            reg_re_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_full_q <= byte_full_d;
            shift_q     <= shift_d;
            sda_oe_q    <= sda_oe_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_we_q    <= reg_we_d;
            reg_re_q    <= reg_re_d;
            busy_q      <= busy_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        byte_full_d = byte_full_q;
        shift_d     = shift_q;
        sda_oe_d    = sda_oe_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_we_d    = 1'b0;
        reg_re_d    = 1'b0;
        busy_d      = busy_q;

        // Post-write increment lands one clk after the strobe, so the strobe
        // cycle still shows the address that was written.
        if (reg_we_q) begin
            reg_addr_d = reg_addr_q + 8'd1;
        end

        // Read data arrives the clk after reg_re. After the address ACK, SCL
        // is already low and no further fall precedes bit 7, so drive bit 7
        // right away. After a master ACK SCL is still high; bit 7 then goes
        // out on the coming SCL fall handled in ST_RDATA.
        if (reg_re_q) begin
            shift_d = reg_rdata;
            if (!scl_lvl) begin
                sda_oe_d = ~reg_rdata[7];
            end
        end

        if (start_det) begin
            state_d     = ST_ADDR;
            bit_cnt_d   = 3'd0;
            byte_full_d = 1'b0;
            sda_oe_d    = 1'b0;
            busy_d      = 1'b0;
        end else if (stop_det) begin
            state_d     = ST_IDLE;
            bit_cnt_d   = 3'd0;
            byte_full_d = 1'b0;
            sda_oe_d    = 1'b0;
            busy_d      = 1'b0;
        end else begin
            if (scl_rise && count_bits) begin
                shift_d = {shift_q[6:0], sda_lvl};
                if (bit_cnt_q == 3'(BYTE_BITS - 1)) begin
                    bit_cnt_d   = 3'd0;
                    byte_full_d = 1'b1;
                end else begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end

            unique case (state_q)
                ST_IDLE: begin
                end

                ST_ADDR: begin
                    if (scl_fall && byte_full_q) begin
                        byte_full_d = 1'b0;
                        if (addr_match(shift_q, SLAVE_ADDR)) begin
                            state_d  = ST_ADDR_ACK;
                            sda_oe_d = 1'b1;
                            busy_d   = 1'b1;
                        end else begin
                            state_d = ST_WAIT_STOP;
                            busy_d  = 1'b0;
                        end
                    end
                end

                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        if (shift_q[0] == RW_READ) begin
                            state_d  = ST_RDATA;
                            reg_re_d = 1'b1;
                        end else begin
                            state_d = ST_MADDR;
                        end
                    end
                end

                ST_MADDR: begin
                    if (scl_fall && byte_full_q) begin
                        byte_full_d = 1'b0;
                        reg_addr_d  = shift_q;
                        sda_oe_d    = 1'b1;
                        state_d     = ST_MADDR_ACK;
                    end
                end

                ST_MADDR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        state_d  = ST_WDATA;
                    end
                end

                ST_WDATA: begin
                    if (scl_fall && byte_full_q) begin
                        byte_full_d = 1'b0;
                        reg_wdata_d = shift_q;
                        reg_we_d    = 1'b1;
                        sda_oe_d    = 1'b1;
                        state_d     = ST_WDATA_ACK;
                    end
                end

                ST_WDATA_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        state_d  = ST_WDATA;
                    end
                end

                ST_RDATA: begin
                    // The rise-side shift above moves the next bit into [7];
                    // each fall presents it, and the fall after the 8th bit
                    // releases SDA for the master's ACK.
                    if (scl_fall) begin
                        if (byte_full_q) begin
                            byte_full_d = 1'b0;
                            sda_oe_d    = 1'b0;
                            state_d     = ST_RDATA_ACK;
                        end else begin
                            sda_oe_d = ~shift_q[7];
                        end
                    end
                end

                ST_RDATA_ACK: begin
                    if (scl_rise) begin
                        if (sda_lvl == ACK_LVL) begin
                            reg_addr_d = reg_addr_q + 8'd1;
                            reg_re_d   = 1'b1;
                            state_d    = ST_RDATA;
                        end else begin
                            state_d = ST_WAIT_STOP;
                        end
                    end
                end

                ST_WAIT_STOP: begin
                    sda_oe_d = 1'b0;
                end

                default: begin
                    state_d  = ST_IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    assign sda_oe    = sda_oe_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign reg_we    = reg_we_q;
    assign reg_re    = reg_re_q;
    assign busy      = busy_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_i2c_target.sv
// -----------------------------------------------------------------------------
// tb_i2c_target
// Directed bench for i2c_target: a bit-banged I2C controller drives SCL and an
// open-drain SDA (wired-AND with the target's sda_oe), a small memory supplies
// reg_rdata, and monitors log every reg_we/reg_re strobe for comparison with
// hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_i2c_target;
    import i2c_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    logic           scl_m;
    logic           sda_m;
    logic           sda_in;
    logic           sda_oe;
    logic [7:0]     reg_addr;
    logic [7:0]     reg_wdata;
    logic           reg_we;
    logic           reg_re;
    logic [7:0]     reg_rdata;
    logic           busy;
    i2c_tgt_state_t state;

    assign sda_in = sda_m & ~sda_oe;

    logic [7:0] mem [256];
    assign reg_rdata = mem[reg_addr];

    i2c_target #(.SLAVE_ADDR(7'h55), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .scl_in    (scl_m),
        .sda_in    (sda_in),
        .sda_oe    (sda_oe),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .busy      (busy),
        .state_o   (state)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q[$];   // expected {addr, data} writes
    logic [15:0] we_q[$];    // observed {addr, data} writes
    logic [7:0]  re_q[$];    // observed read addresses

    always @(negedge clk) begin
        if (reg_we) we_q.push_back({reg_addr, reg_wdata});
        if (reg_re) re_q.push_back(reg_addr);
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_writes(input string tag);
        chk({tag, "_we_count"}, 16'(we_q.size()), 16'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < we_q.size()) chk({tag, "_we_entry"}, we_q[i], exp_q[i]);
        end
        exp_q.delete();
        we_q.delete();
    endtask

    // ---------------- driver tasks ----------------
    localparam int Q = 4;   // quarter SCL period in clk cycles

    task automatic q();
        repeat (Q) @(negedge clk);
    endtask

    // One SCL clock starting and ending with SCL low; returns SDA seen at mid-high.
    task automatic bit_io(input logic b, output logic s);
        q(); sda_m = b;
        q(); scl_m = 1'b1;
        q(); s = sda_in;
        q(); scl_m = 1'b0;
    endtask

    task automatic i2c_start();
        q(); sda_m = 1'b1;
        q(); scl_m = 1'b1;
        q(); sda_m = 1'b0;
        q(); scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        q(); sda_m = 1'b0;
        q(); scl_m = 1'b1;
        q(); sda_m = 1'b1;
        q();
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_io(b[i], s);
        bit_io(1'b1, ack);
    endtask

    task automatic recv_byte(output logic [7:0] d, input logic ack_bit);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_io(1'b1, s);
            d[i] = s;
        end
        bit_io(ack_bit, s);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic       ack;
        logic [7:0] d;
        logic       s;

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h10] = 8'h3C;
        mem[8'h11] = 8'hC3;
        reset = 1'b1;
        scl_m = 1'b1;
        sda_m = 1'b1;
        repeat (4) @(negedge clk);

        // Reset values
        chk("rst_sda_oe",    16'(sda_oe),    16'h0);
        chk("rst_reg_addr",  16'(reg_addr),  16'h0);
        chk("rst_reg_wdata", 16'(reg_wdata), 16'h0);
        chk("rst_reg_we",    16'(reg_we),    16'h0);
        chk("rst_reg_re",    16'(reg_re),    16'h0);
        chk("rst_busy",      16'(busy),      16'h0);
        chk("rst_state",     16'(state),     16'(ST_IDLE));
        reset = 1'b0;
        q();

        // Write: 0xAA, 0x55, 0x77, 0x22
        i2c_start();
        send_byte(8'hAA, ack); chk("wr_ack_addr", 16'(ack), 16'h0);
        chk("wr_busy", 16'(busy), 16'h1);
        send_byte(8'h55, ack); chk("wr_ack_maddr", 16'(ack), 16'h0);
        send_byte(8'h77, ack); chk("wr_ack_d0", 16'(ack), 16'h0);
        send_byte(8'h22, ack); chk("wr_ack_d1", 16'(ack), 16'h0);
        exp_q.push_back({8'h55, 8'h77});
        exp_q.push_back({8'h56, 8'h22});
        i2c_stop();
        q();
        chk("wr_busy_after_stop", 16'(busy), 16'h0);
        chk("wr_state_idle", 16'(state), 16'(ST_IDLE));
        chk("wr_reg_addr_final", 16'(reg_addr), 16'h57);
        check_writes("wr");
        chk("wr_no_reads", 16'(re_q.size()), 16'h0);
        re_q.delete();

        // Combined write-address / read: 0xAA 0x10 rSTART 0xAB, read 2 bytes
        i2c_start();
        send_byte(8'hAA, ack); chk("rd_ack_addr", 16'(ack), 16'h0);
        send_byte(8'h10, ack); chk("rd_ack_maddr", 16'(ack), 16'h0);
        i2c_start();
        send_byte(8'hAB, ack); chk("rd_ack_raddr", 16'(ack), 16'h0);
        chk("rd_busy", 16'(busy), 16'h1);
        recv_byte(d, 1'b0); chk("rd_byte0", 16'(d), 16'h3C);
        recv_byte(d, 1'b1); chk("rd_byte1", 16'(d), 16'hC3);
        q();
        chk("rd_sda_oe_after_nack", 16'(sda_oe), 16'h0);
        chk("rd_state_wait_stop", 16'(state), 16'(ST_WAIT_STOP));
        chk("rd_re_count", 16'(re_q.size()), 16'h2);
        if (re_q.size() >= 2) begin
            chk("rd_re_addr0", 16'(re_q[0]), 16'h10);
            chk("rd_re_addr1", 16'(re_q[1]), 16'h11);
        end
        re_q.delete();
        i2c_stop();
        q();
        chk("rd_state_idle", 16'(state), 16'(ST_IDLE));
        check_writes("rd");

        // Address mismatch: 0x88 (address 0x44)
        i2c_start();
        send_byte(8'h88, ack); chk("mm_nack", 16'(ack), 16'h1);
        chk("mm_state_wait_stop", 16'(state), 16'(ST_WAIT_STOP));
        chk("mm_busy", 16'(busy), 16'h0);
        send_byte(8'h00, ack); chk("mm_nack_data", 16'(ack), 16'h1);
        chk("mm_state_still_wait", 16'(state), 16'(ST_WAIT_STOP));
        i2c_stop();
        q();
        chk("mm_state_idle", 16'(state), 16'(ST_IDLE));
        chk("mm_no_reads", 16'(re_q.size()), 16'h0);
        check_writes("mm");

        // Address wrap: write 0x01, 0x02 from 0xFF
        i2c_start();
        send_byte(8'hAA, ack); chk("wrap_ack_addr", 16'(ack), 16'h0);
        send_byte(8'hFF, ack); chk("wrap_ack_maddr", 16'(ack), 16'h0);
        send_byte(8'h01, ack); chk("wrap_ack_d0", 16'(ack), 16'h0);
        send_byte(8'h02, ack); chk("wrap_ack_d1", 16'(ack), 16'h0);
        exp_q.push_back({8'hFF, 8'h01});
        exp_q.push_back({8'h00, 8'h02});
        i2c_stop();
        q();
        chk("wrap_reg_addr_final", 16'(reg_addr), 16'h01);
        check_writes("wrap");

        // STOP after 4 bits of a data byte
        i2c_start();
        send_byte(8'hAA, ack); chk("abort_ack_addr", 16'(ack), 16'h0);
        send_byte(8'h30, ack); chk("abort_ack_maddr", 16'(ack), 16'h0);
        bit_io(1'b1, s);
        bit_io(1'b0, s);
        bit_io(1'b1, s);
        bit_io(1'b0, s);
        i2c_stop();
        q();
        chk("abort_state_idle", 16'(state), 16'(ST_IDLE));
        chk("abort_reg_addr", 16'(reg_addr), 16'h30);
        check_writes("abort");

        // Reset during RDATA bit 3 (mem[0x20] = 0x00, so target holds SDA low)
        i2c_start();
        send_byte(8'hAA, ack);
        send_byte(8'h20, ack);
        i2c_start();
        send_byte(8'hAB, ack); chk("rst_rd_ack", 16'(ack), 16'h0);
        bit_io(1'b1, s);
        bit_io(1'b1, s);
        bit_io(1'b1, s);
        bit_io(1'b1, s);
        q(); scl_m = 1'b1;
        q();
        chk("rst_rd_sda_oe_before", 16'(sda_oe), 16'h1);
        chk("rst_rd_state_rdata", 16'(state), 16'(ST_RDATA));
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_rd_sda_oe_next_clk", 16'(sda_oe), 16'h0);
        chk("rst_rd_state_idle", 16'(state), 16'(ST_IDLE));
        @(negedge clk);
        reset = 1'b0;
        re_q.delete();
        q();

        // Fresh write after reset
        i2c_start();
        send_byte(8'hAA, ack); chk("post_ack_addr", 16'(ack), 16'h0);
        send_byte(8'h40, ack); chk("post_ack_maddr", 16'(ack), 16'h0);
        send_byte(8'h5A, ack); chk("post_ack_d0", 16'(ack), 16'h0);
        exp_q.push_back({8'h40, 8'h5A});
        i2c_stop();
        q();
        chk("post_state_idle", 16'(state), 16'(ST_IDLE));
        check_writes("post");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
